vx_smem_responder: RTL

//  Memory-side responder for the per-thread D$ request/response interface driven by the LSU.

---
 rtl/vx_smem_responder.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/vx_smem_responder.sv
// vx_smem_responder: banked shared-memory responder for the per-lane LSU request interface.
// Accepts up to NUM_REQS lane requests per cycle, arbitrates bank conflicts, writes stores
// silently and returns loads as partial responses (tmask + tag) one cycle after they fire.
//
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   req_valid    per-lane request valid
//   req_rw       per-lane kind, 1 = store, 0 = load
//   req_addr     per-lane word address (bank = low bits, row = next bits, rest ignored)
//   req_byteen   per-lane store byte enables
//   req_data     per-lane store data
//   req_tag      per-lane tag
//   req_ready    per-lane accept (combinational)
//   rsp_valid    load response valid
//   rsp_tmask    lanes carried by the response
//   rsp_data     per-lane load data (lanes outside rsp_tmask are don't-care)
//   rsp_tag      tag of the served lanes
//   rsp_ready    consumer accept
// NUM_BANKS must be at least 2 and ADDR_WIDTH must exceed the bank + row bits.
module vx_smem_responder #(
    parameter int unsigned NUM_REQS   = 4,
    parameter int unsigned NUM_BANKS  = 4,
    parameter int unsigned BANK_WORDS = 256,
    parameter int unsigned ADDR_WIDTH = 30,
    parameter int unsigned TAG_WIDTH  = 8
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_REQS-1:0]              req_valid,
    input  logic [NUM_REQS-1:0]              req_rw,
    input  logic [NUM_REQS*ADDR_WIDTH-1:0]   req_addr,
    input  logic [NUM_REQS*4-1:0]            req_byteen,
    input  logic [NUM_REQS*32-1:0]           req_data,
    input  logic [NUM_REQS*TAG_WIDTH-1:0]    req_tag,
    output logic [NUM_REQS-1:0]              req_ready,
    output logic                             rsp_valid,
    output logic [NUM_REQS-1:0]              rsp_tmask,
    output logic [NUM_REQS*32-1:0]           rsp_data,
    output logic [TAG_WIDTH-1:0]             rsp_tag,
    input  logic                             rsp_ready
);

    localparam int unsigned BANK_BITS = $clog2(NUM_BANKS);
    localparam int unsigned ROW_BITS  = $clog2(BANK_WORDS);
    localparam int unsigned LANE_BITS = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;
    localparam int unsigned USED_BITS = BANK_BITS + ROW_BITS;

    logic [31:0]          mem [NUM_BANKS][BANK_WORDS];

    logic [BANK_BITS-1:0] lane_bank [NUM_REQS];
    logic [ROW_BITS-1:0]  lane_row  [NUM_REQS];
    logic                 lead_found;
    logic                 lead_rw;
    logic [TAG_WIDTH-1:0] lead_tag;
    logic [NUM_REQS-1:0]  cand;
    logic [NUM_REQS-1:0]  grant;
    logic [NUM_BANKS-1:0] bank_has;
    logic [NUM_BANKS-1:0] bank_we;
    logic [LANE_BITS-1:0] win_idx   [NUM_BANKS];
    logic [ROW_BITS-1:0]  win_row   [NUM_BANKS];
    logic [31:0]          win_data  [NUM_BANKS];
    logic [3:0]           win_be    [NUM_BANKS];
    logic [31:0]          rd_word   [NUM_BANKS];
    logic [NUM_REQS-1:0]  load_fire;
    logic                 stall;
    logic                 unused_addr_bits;

    assign stall = rsp_valid & ~rsp_ready;

    // Lead lane selection, candidate set, per-bank winner and lane grants.
    always_comb begin
        lead_found = 1'b0;
        lead_rw    = 1'b0;
        lead_tag   = '0;
        cand       = '0;
        grant      = '0;
        req_ready  = '0;
        bank_has   = '0;
        bank_we    = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            win_idx[b]  = '0;
            win_row[b]  = '0;
            win_data[b] = '0;
            win_be[b]   = '0;
        end

        for (int i = 0; i < NUM_REQS; i++) begin
            lane_bank[i] = req_addr[i*ADDR_WIDTH +: BANK_BITS];
            lane_row[i]  = req_addr[i*ADDR_WIDTH + BANK_BITS +: ROW_BITS];
            if (req_valid[i] && !lead_found) begin
                lead_found = 1'b1;
                lead_rw    = req_rw[i];
                lead_tag   = req_tag[i*TAG_WIDTH +: TAG_WIDTH];
            end
        end

        for (int i = 0; i < NUM_REQS; i++) begin
            cand[i] = req_valid[i] && (req_rw[i] == lead_rw)
                      && (req_tag[i*TAG_WIDTH +: TAG_WIDTH] == lead_tag);
        end

        // Ascending scan: the first candidate seen on a bank owns it.
        for (int i = 0; i < NUM_REQS; i++) begin
            if (cand[i] && !bank_has[lane_bank[i]]) begin
                bank_has[lane_bank[i]] = 1'b1;
                win_idx[lane_bank[i]]  = LANE_BITS'(i);
                win_row[lane_bank[i]]  = lane_row[i];
                win_data[lane_bank[i]] = req_data[i*32 +: 32];
                win_be[lane_bank[i]]   = req_byteen[i*4 +: 4];
            end
        end

        // Stores: only the bank owner. Loads: every lane sharing the owner's row.
        for (int i = 0; i < NUM_REQS; i++) begin
            if (lead_rw) begin
                grant[i] = cand[i] && (win_idx[lane_bank[i]] == LANE_BITS'(i));
            end else begin
                grant[i] = cand[i] && (win_row[lane_bank[i]] == lane_row[i]);
            end
            req_ready[i] = grant[i] && (lead_rw || !stall);
        end

        for (int b = 0; b < NUM_BANKS; b++) begin
            bank_we[b] = bank_has[b] && lead_rw;
        end
    end

    assign load_fire = req_valid & req_ready & {NUM_REQS{~lead_rw}};

    // One read per bank at the owner's row; broadcast lanes share it.
    always_comb begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            rd_word[b] = mem[b][win_row[b]];
        end
    end

    // Bank writes, byte-masked; suppressed while reset is asserted.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                if (bank_we[b]) begin
                    for (int k = 0; k < 4; k++) begin
                        if (win_be[b][k]) begin
                            mem[b][win_row[b]][8*k +: 8] <= win_data[b][8*k +: 8];
                        end
                    end
                end
            end
        end
    end

    // Response control: holds while stalled, replaced back-to-back on pop.
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid <= 1'b0;
            rsp_tmask <= '0;
        end else if (!stall) begin
            rsp_valid <= |load_fire;
            rsp_tmask <= load_fire;
        end
    end

    // Response payload: only loaded when a load fires (never while stalled).
    always_ff @(posedge clk) begin
        if (|load_fire) begin
            rsp_tag <= lead_tag;
            for (int i = 0; i < NUM_REQS; i++) begin
                rsp_data[i*32 +: 32] <= rd_word[lane_bank[i]];
            end
        end
    end

    // Upper address bits alias by design.
    always_comb begin
        unused_addr_bits = 1'b0;
        for (int i = 0; i < NUM_REQS; i++) begin
            unused_addr_bits = unused_addr_bits
                               ^ (^req_addr[i*ADDR_WIDTH + USED_BITS +: ADDR_WIDTH - USED_BITS]);
        end
    end

endmodule
